// File: rtl/imm_gen_pkg.sv
// Shared immediate-format encoding and RV32/RV64 base opcodes
// used by the immediate decoder and the skid-buffer control.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction: instruction word to
// extended immediate, format code and illegal-opcode flag.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit EN_ZIMM = 1'b1
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       shamt_op;

  assign opc      = inst[6:0];
  assign f3       = inst[14:12];
  assign shamt_op = (f3 == 3'b001) || (f3 == 3'b101);

  // Pick the format from the opcode and build its immediate
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    unique case (opc)
      OPC_LOAD, OPC_JALR: begin
        fmt = FMT_I;
        imm = XLEN'($signed(inst[31:20]));
      end
      OPC_OP_IMM: begin
        if (shamt_op) begin
          fmt = FMT_SHAMT;
          imm = (XLEN == 64) ? XLEN'(inst[25:20])
                             : XLEN'(inst[24:20]);
        end else begin
          fmt = FMT_I;
          imm = XLEN'($signed(inst[31:20]));
        end
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = XLEN'($signed({inst[31], inst[7],
                             inst[30:25], inst[11:8],
                             1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = XLEN'($signed({inst[31:12], 12'b0}));
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = XLEN'($signed({inst[31], inst[19:12],
                             inst[20], inst[30:21],
                             1'b0}));
      end
      OPC_OP: begin
        fmt = FMT_NONE;
      end
      OPC_SYSTEM: begin
        // Register-operand SYSTEM forms carry no immediate
        if (f3[2]) begin
          if (EN_ZIMM) begin
            fmt = FMT_ZIMM;
            imm = XLEN'(inst[19:15]);
          end else begin
            illegal = 1'b1;
          end
        end
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator behind a 2-entry skid buffer
// (main entry drives the outputs, skid absorbs one stall).
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit EN_ZIMM = 1'b1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     INSTRUCTION,
  input  logic [XLEN-1:0] PC_IN,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] IMM_OUT,
  output logic [2:0]      IMM_FMT,
  output logic            IMM_ILLEGAL,
  output logic [XLEN-1:0] PC_OUT
);

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  imm_decode #(
    .XLEN    (XLEN),
    .EN_ZIMM (EN_ZIMM)
  ) u_dec (
    .inst    (INSTRUCTION),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  logic            main_vld_q, main_vld_d;
  logic [XLEN-1:0] main_imm_q, main_imm_d;
  logic [2:0]      main_fmt_q, main_fmt_d;
  logic            main_ill_q, main_ill_d;
  logic [XLEN-1:0] main_pc_q,  main_pc_d;
  logic            skid_vld_q, skid_vld_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic [2:0]      skid_fmt_q, skid_fmt_d;
  logic            skid_ill_q, skid_ill_d;
  logic [XLEN-1:0] skid_pc_q,  skid_pc_d;
  logic            rdy_q,      rdy_d;

  logic acc;
  logic drn;

  assign acc = IN_VALID & rdy_q;
  assign drn = main_vld_q & OUT_READY;

  // Advance entries: skid refills main first, else new input
  always_comb begin
    main_vld_d = main_vld_q;
    main_imm_d = main_imm_q;
    main_fmt_d = main_fmt_q;
    main_ill_d = main_ill_q;
    main_pc_d  = main_pc_q;
    skid_vld_d = skid_vld_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    skid_ill_d = skid_ill_q;
    skid_pc_d  = skid_pc_q;
    if (FLUSH) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || drn) begin
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_imm_d = skid_imm_q;
        main_fmt_d = skid_fmt_q;
        main_ill_d = skid_ill_q;
        main_pc_d  = skid_pc_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = acc;
        if (acc) begin
          main_imm_d = dec_imm;
          main_fmt_d = dec_fmt;
          main_ill_d = dec_ill;
          main_pc_d  = PC_IN;
        end
      end
    end else if (acc) begin
      skid_vld_d = 1'b1;
      skid_imm_d = dec_imm;
      skid_fmt_d = dec_fmt;
      skid_ill_d = dec_ill;
      skid_pc_d  = PC_IN;
    end
    rdy_d = !skid_vld_d;
  end

  // Entry and ready registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      main_vld_q <= 1'b0;
      main_imm_q <= '0;
      main_fmt_q <= FMT_NONE;
      main_ill_q <= 1'b0;
      main_pc_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_imm_q <= '0;
      skid_fmt_q <= FMT_NONE;
      skid_ill_q <= 1'b0;
      skid_pc_q  <= '0;
      rdy_q      <= 1'b1;
    end else begin
      main_vld_q <= main_vld_d;
      main_imm_q <= main_imm_d;
      main_fmt_q <= main_fmt_d;
      main_ill_q <= main_ill_d;
      main_pc_q  <= main_pc_d;
      skid_vld_q <= skid_vld_d;
      skid_imm_q <= skid_imm_d;
      skid_fmt_q <= skid_fmt_d;
      skid_ill_q <= skid_ill_d;
      skid_pc_q  <= skid_pc_d;
      rdy_q      <= rdy_d;
    end
  end

  assign IN_READY    = rdy_q;
  assign OUT_VALID   = main_vld_q;
  assign IMM_OUT     = main_imm_q;
  assign IMM_FMT     = main_fmt_q;
  assign IMM_ILLEGAL = main_ill_q;
  assign PC_OUT      = main_pc_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench driving XLEN=32 and XLEN=64 instances
// with identical stimulus and per-width expected values.
module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  localparam logic [2:0] F_NONE  = 3'd0;
  localparam logic [2:0] F_I     = 3'd1;
  localparam logic [2:0] F_S     = 3'd2;
  localparam logic [2:0] F_B     = 3'd3;
  localparam logic [2:0] F_U     = 3'd4;
  localparam logic [2:0] F_J     = 3'd5;
  localparam logic [2:0] F_SHAMT = 3'd6;
  localparam logic [2:0] F_ZIMM  = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [63:0] pc64;

  logic        rdy32, rdy64, ov32, ov64, ill32, ill64;
  logic [31:0] imm32, pco32;
  logic [63:0] imm64, pco64;
  logic [2:0]  fmt32, fmt64;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;

  assign pc64 = {32'h8000_0001, pc};

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .EN_ZIMM(1'b1)) u_dut32 (
    .CLK         (clk),
    .RESET       (rst),
    .FLUSH       (flush),
    .IN_VALID    (in_valid),
    .IN_READY    (rdy32),
    .INSTRUCTION (instr),
    .PC_IN       (pc),
    .OUT_VALID   (ov32),
    .OUT_READY   (out_ready),
    .IMM_OUT     (imm32),
    .IMM_FMT     (fmt32),
    .IMM_ILLEGAL (ill32),
    .PC_OUT      (pco32)
  );

  imm_gen_pipe #(.XLEN(64), .EN_ZIMM(1'b1)) u_dut64 (
    .CLK         (clk),
    .RESET       (rst),
    .FLUSH       (flush),
    .IN_VALID    (in_valid),
    .IN_READY    (rdy64),
    .INSTRUCTION (instr),
    .PC_IN       (pc64),
    .OUT_VALID   (ov64),
    .OUT_READY   (out_ready),
    .IMM_OUT     (imm64),
    .IMM_FMT     (fmt64),
    .IMM_ILLEGAL (ill64),
    .PC_OUT      (pco64)
  );

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every presented-and-accepted output pops one entry
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && !flush && out_ready && (ov32 || ov64)) begin
      chk("valid_sync", {63'd0, ov64}, {63'd0, ov32});
      if (q.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        pops++;
        chk("imm32", {32'd0, imm32}, {32'd0, e.imm32});
        chk("fmt32", {61'd0, fmt32}, {61'd0, e.fmt});
        chk("ill32", {63'd0, ill32}, {63'd0, e.ill});
        chk("pc32",  {32'd0, pco32}, {32'd0, e.pc});
        chk("imm64", imm64, e.imm64);
        chk("fmt64", {61'd0, fmt64}, {61'd0, e.fmt});
        chk("ill64", {63'd0, ill64}, {63'd0, e.ill});
        chk("pc64",  pco64, {32'h8000_0001, e.pc});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] i,
                      input logic [31:0] e32,
                      input logic [63:0] e64,
                      input logic [2:0]  f,
                      input logic        il);
    exp_t e;
    int   n;
    instr    = i;
    in_valid = 1'b1;
    n        = 0;
    while (!rdy32 && n < 50) begin
      cyc(1);
      n++;
    end
    if (!rdy32) begin
      chk("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    e.imm32 = e32;
    e.imm64 = e64;
    e.fmt   = f;
    e.ill   = il;
    e.pc    = pc;
    q.push_back(e);
    cyc(1);
    pc       = pc + 32'd4;
    in_valid = 1'b0;
  endtask

  initial begin : stim
    int          p0;
    logic [31:0] pc_a;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = 32'd0;
    pc        = 32'h0000_1000;
    #12;
    chk("rst_ov",   {63'd0, ov32}, 64'd0);
    chk("rst_rdy",  {63'd0, rdy32}, 64'd1);
    chk("rst_imm",  {32'd0, imm32}, 64'd0);
    chk("rst_fmt",  {61'd0, fmt32}, {61'd0, F_NONE});
    chk("rst_ill",  {63'd0, ill32}, 64'd0);
    chk("rst_pc",   {32'd0, pco32}, 64'd0);
    chk("rst_64",   {ov64, ill64, fmt64, imm64 | pco64},
                    {1'b0, 1'b0, 3'd0, 64'd0});
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;

    // single addi, one-cycle latency
    send(32'hFFF00093, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, F_I, 1'b0);
    chk("latency_ov", {63'd0, ov32}, 64'd1);
    cyc(2);

    // store then branch, consecutive cycles
    send(32'hFE20AE23, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, F_S, 1'b0);
    chk("sw_imm", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFC);
    send(32'hFE000CE3, 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, F_B, 1'b0);
    chk("beq_imm", {32'd0, imm32}, 64'h0000_0000_FFFF_FFF8);
    send(32'h0000007F, 32'h0, 64'h0, F_NONE, 1'b1);
    send(32'h0080006F, 32'h8, 64'h8, F_J, 1'b0);
    send(32'hFFDFF06F, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, F_J, 1'b0);
    send(32'h3002D073, 32'h5, 64'h5, F_ZIMM, 1'b0);
    send(32'h002081B3, 32'h0, 64'h0, F_NONE, 1'b0);
    send(32'h4030D093, 32'h3, 64'h3, F_SHAMT, 1'b0);
    send(32'h7FF02083, 32'h7FF, 64'h7FF, F_I, 1'b0);
    send(32'h800080E7, 32'hFFFF_F800, 64'hFFFF_FFFF_FFFF_F800, F_I, 1'b0);
    send(32'h123450B7, 32'h1234_5000, 64'h0000_0000_1234_5000, F_U, 1'b0);
    send(32'h800000B7, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, F_U, 1'b0);
    send(32'h01F09093, 32'h1F, 64'h1F, F_SHAMT, 1'b0);
    send(32'h03F09093, 32'h1F, 64'h3F, F_SHAMT, 1'b0);
    cyc(3);

    // stall: fill main + skid, third held off
    out_ready = 1'b0;
    p0        = pops;
    pc_a      = pc;
    send(32'h7FF02083, 32'h7FF, 64'h7FF, F_I, 1'b0);
    chk("rdy_after_1", {63'd0, rdy32}, 64'd1);
    send(32'hFFF00093, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, F_I, 1'b0);
    chk("rdy_after_2", {63'd0, rdy32}, 64'd0);
    chk("rdy64_after_2", {63'd0, rdy64}, 64'd0);
    instr    = 32'h0080006F;
    in_valid = 1'b1;
    cyc(2);
    chk("rdy_held", {63'd0, rdy32}, 64'd0);
    chk("stall_ov", {63'd0, ov32}, 64'd1);
    chk("stall_imm", {32'd0, imm32}, 64'h7FF);
    chk("stall_pc", {32'd0, pco32}, {32'd0, pc_a});
    out_ready = 1'b1;
    send(32'h0080006F, 32'h8, 64'h8, F_J, 1'b0);
    cyc(4);
    chk("drain_count", 64'(pops - p0), 64'd3);

    // flush with both entries held and input pending
    out_ready = 1'b0;
    send(32'h002081B3, 32'h0, 64'h0, F_NONE, 1'b0);
    send(32'h3002D073, 32'h5, 64'h5, F_ZIMM, 1'b0);
    chk("pre_flush_rdy", {63'd0, rdy32}, 64'd0);
    flush     = 1'b1;
    instr     = 32'h0080006F;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("flush_ov", {63'd0, ov32}, 64'd0);
    chk("flush_rdy", {63'd0, rdy32}, 64'd1);
    chk("flush_ov64", {63'd0, ov64}, 64'd0);
    cyc(3);
    chk("post_flush_ov", {63'd0, ov32}, 64'd0);

    // reset while stalled drops held entries
    out_ready = 1'b0;
    send(32'h7FF02083, 32'h7FF, 64'h7FF, F_I, 1'b0);
    send(32'hFE20AE23, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, F_S, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ov", {63'd0, ov32}, 64'd0);
    chk("arst_rdy", {63'd0, rdy32}, 64'd1);
    chk("arst_imm_pc", {imm32, pco32}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    p0        = pops;
    out_ready = 1'b1;
    cyc(3);
    chk("post_rst_ov", {63'd0, ov32}, 64'd0);
    chk("post_rst_pops", 64'(pops - p0), 64'd0);

    // ready recovers and normal traffic resumes
    send(32'h3002D073, 32'h5, 64'h5, F_ZIMM, 1'b0);
    cyc(3);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
